ethernet_mmio_arbiter: RTL and testbench

ETHERNET_MMIO_ARBITER -- requirements
Module: ethernet_mmio_arbiter

---
 rtl/ethernet_mmio_arbiter.sv | 123 ++++++++++++
 tb/tb_ethernet_mmio_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/ethernet_mmio_arbiter.sv
// Two-requester round-robin arbiter in front of a single-outstanding MMIO controller port.
// Misaligned requests are answered with an error and never reach the controller.
module ethernet_mmio_arbiter #(
    parameter int data_width_p = 32,
    parameter int addr_width_p = 14,
    localparam int size_width_lp = (data_width_p > 8) ? $clog2(data_width_p / 8) : 1
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic [1:0]                   req_v_i,
    output logic [1:0]                   req_ready_o,
    input  logic [1:0]                   req_we_i,
    input  logic [2*addr_width_p-1:0]    req_addr_i,
    input  logic [2*size_width_lp-1:0]   req_size_i,
    input  logic [2*data_width_p-1:0]    req_data_i,
    output logic [1:0]                   resp_v_o,
    output logic [data_width_p-1:0]      resp_data_o,
    output logic                         resp_err_o,
    input  logic [1:0]                   resp_yumi_i,
    output logic [addr_width_p-1:0]      addr_o,
    output logic                         write_en_o,
    output logic                         read_en_o,
    output logic [size_width_lp-1:0]     op_size_o,
    output logic [data_width_p-1:0]      write_data_o,
    input  logic [data_width_p-1:0]      read_data_i
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_e;

    state_e                     state_q;
    logic                       ptr_q, grant_q, we_q;
    logic [addr_width_p-1:0]    addr_q;
    logic [size_width_lp-1:0]   size_q;
    logic [data_width_p-1:0]    data_q, resp_data_q;
    logic                       resp_err_q, wen_q, ren_q;
    logic [1:0]                 resp_v_q;

    logic                       win;
    logic [1:0]                 ready;
    logic                       win_we, win_mis;
    logic [addr_width_p-1:0]    win_addr, win_mask;
    logic [size_width_lp-1:0]   win_size;
    logic [data_width_p-1:0]    win_data;

    // Pointer only matters when both are valid; a lone requester always wins.
    always_comb begin
        win      = req_v_i[1] & (~req_v_i[0] | ptr_q);
        ready    = 2'b00;
        if (state_q == IDLE && !reset_i && req_v_i != 2'b00)
            ready = win ? 2'b10 : 2'b01;
        win_we   = win ? req_we_i[1] : req_we_i[0];
        win_addr = win ? req_addr_i[2*addr_width_p-1:addr_width_p] : req_addr_i[addr_width_p-1:0];
        win_size = win ? req_size_i[2*size_width_lp-1:size_width_lp] : req_size_i[size_width_lp-1:0];
        win_data = win ? req_data_i[2*data_width_p-1:data_width_p] : req_data_i[data_width_p-1:0];
        win_mask = (addr_width_p'(1) << win_size) - addr_width_p'(1);
        win_mis  = (win_addr & win_mask) != '0;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            ptr_q       <= 1'b0;
            grant_q     <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            size_q      <= '0;
            data_q      <= '0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
            resp_v_q    <= 2'b00;
            wen_q       <= 1'b0;
            ren_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (ready != 2'b00) begin
                    grant_q <= win;
                    we_q    <= win_we;
                    addr_q  <= win_addr;
                    size_q  <= win_size;
                    data_q  <= win_data;
                    if (win_mis) begin
                        state_q     <= RESP;
                        resp_v_q    <= ready;
                        resp_err_q  <= 1'b1;
                        resp_data_q <= '0;
                    end else begin
                        state_q <= ISSUE;
                        wen_q   <= win_we;
                        ren_q   <= ~win_we;
                    end
                end
                ISSUE: begin
                    wen_q   <= 1'b0;
                    ren_q   <= 1'b0;
                    state_q <= CAPTURE;
                end
                CAPTURE: begin
                    resp_data_q <= we_q ? '0 : read_data_i;
                    resp_err_q  <= 1'b0;
                    resp_v_q    <= grant_q ? 2'b10 : 2'b01;
                    state_q     <= RESP;
                end
                RESP: if (resp_yumi_i[grant_q]) begin
                    resp_v_q <= 2'b00;
                    ptr_q    <= ~grant_q;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready_o  = ready;
    assign resp_v_o     = resp_v_q;
    assign resp_data_o  = resp_data_q;
    assign resp_err_o   = resp_err_q;
    assign addr_o       = addr_q;
    assign op_size_o    = size_q;
    assign write_data_o = data_q;
    assign write_en_o   = wen_q;
    assign read_en_o    = ren_q;

endmodule

// File: tb/tb_ethernet_mmio_arbiter.sv
// Directed plus randomized bench for ethernet_mmio_arbiter; a transaction-level model
// predicts grant, controller command and response from the arbitration/alignment rules.
module tb_ethernet_mmio_arbiter;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [1:0]  req_v_i, req_ready_o, req_we_i, resp_v_o, resp_yumi_i;
    logic [27:0] req_addr_i;
    logic [3:0]  req_size_i;
    logic [63:0] req_data_i;
    logic [31:0] resp_data_o, write_data_o, read_data_i;
    logic        resp_err_o, write_en_o, read_en_o;
    logic [13:0] addr_o;
    logic [1:0]  op_size_o;

    ethernet_mmio_arbiter dut (
        .clk_i(clk_i), .reset_i(reset_i), .req_v_i(req_v_i), .req_ready_o(req_ready_o),
        .req_we_i(req_we_i), .req_addr_i(req_addr_i), .req_size_i(req_size_i),
        .req_data_i(req_data_i), .resp_v_o(resp_v_o), .resp_data_o(resp_data_o),
        .resp_err_o(resp_err_o), .resp_yumi_i(resp_yumi_i), .addr_o(addr_o),
        .write_en_o(write_en_o), .read_en_o(read_en_o), .op_size_o(op_size_o),
        .write_data_o(write_data_o), .read_data_i(read_data_i)
    );

    always #5 clk_i = ~clk_i;

    int          checks = 0, failures = 0;
    logic        ptr_m;
    logic        we_r[2];
    logic [13:0] addr_r[2];
    logic [1:0]  size_r[2];
    logic [31:0] data_r[2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic apply();
        req_we_i   = {we_r[1], we_r[0]};
        req_addr_i = {addr_r[1], addr_r[0]};
        req_size_i = {size_r[1], size_r[0]};
        req_data_i = {data_r[1], data_r[0]};
    endtask

    task automatic set_req(input int n, input logic we, input logic [13:0] a,
                           input logic [1:0] sz, input logic [31:0] d);
        we_r[n] = we; addr_r[n] = a; size_r[n] = sz; data_r[n] = d;
    endtask

    // One complete transaction: offer v, predict the winner, follow it to yumi.
    task automatic txn(input logic [1:0] v, input logic keep_v, input int dly, input logic [31:0] rd);
        int          w;
        logic        mis, sw;
        logic [13:0] sa;
        logic [1:0]  ss;
        logic [31:0] sd, exp_data;
        logic [1:0]  onehot, other;
        w      = (v == 2'b11) ? int'(ptr_m) : (v[1] ? 1 : 0);
        onehot = (w == 1) ? 2'b10 : 2'b01;
        other  = (w == 1) ? 2'b01 : 2'b10;
        mis    = (int'(addr_r[w]) % (1 << size_r[w])) != 0;
        sw = we_r[w]; sa = addr_r[w]; ss = size_r[w]; sd = data_r[w];
        exp_data = (mis || sw) ? 32'h0 : rd;
        apply();
        req_v_i = v;
        resp_yumi_i = 2'b00;
        #1;
        chk("ready_idle", req_ready_o, onehot);
        tick();
        if (!keep_v) begin
            req_v_i = 2'b00;
            req_we_i = 2'($urandom); req_addr_i = 28'($urandom);
            req_size_i = 4'($urandom); req_data_i = {$urandom, $urandom};
        end
        if (!mis) begin
            chk("issue_wen", write_en_o, sw);
            chk("issue_ren", read_en_o, !sw);
            chk("issue_addr", addr_o, sa);
            chk("issue_size", op_size_o, ss);
            if (sw) chk("issue_wdata", write_data_o, sd);
            chk("issue_ready", req_ready_o, 2'b00);
            chk("issue_respv", resp_v_o, 2'b00);
            read_data_i = $urandom;
            tick();
            read_data_i = rd;
            chk("capture_en", {write_en_o, read_en_o}, 2'b00);
            chk("capture_respv", resp_v_o, 2'b00);
            tick();
            read_data_i = $urandom;
        end
        req_v_i = 2'b11;
        for (int i = 0; i <= dly; i++) begin
            resp_yumi_i = (i == dly) ? onehot : other;
            #1;
            chk("resp_v", resp_v_o, onehot);
            chk("resp_data", resp_data_o, exp_data);
            chk("resp_err", resp_err_o, mis);
            chk("resp_ready", req_ready_o, 2'b00);
            chk("resp_en", {write_en_o, read_en_o}, 2'b00);
            chk("resp_addr_hold", addr_o, mis ? addr_o : sa);
            tick();
        end
        resp_yumi_i = 2'b00;
        if (!keep_v) req_v_i = 2'b00;
        chk("post_yumi_respv", resp_v_o, 2'b00);
        ptr_m = (w == 0);
    endtask

    initial begin
        reset_i = 1'b1; req_v_i = 2'b11; resp_yumi_i = 2'b00; read_data_i = '0;
        set_req(0, 1'b0, 14'h0, 2'd0, 32'h0);
        set_req(1, 1'b0, 14'h0, 2'd0, 32'h0);
        apply();
        ptr_m = 1'b0;
        tick(); tick();
        chk("rst_ready", req_ready_o, 2'b00);
        chk("rst_respv", resp_v_o, 2'b00);
        chk("rst_data", resp_data_o, 32'h0);
        chk("rst_err", resp_err_o, 1'b0);
        chk("rst_en", {write_en_o, read_en_o}, 2'b00);
        chk("rst_addr", addr_o, 14'h0);
        reset_i = 1'b0; req_v_i = 2'b00;
        tick();

        // single read, write, misaligned write
        set_req(0, 1'b0, 14'h0010, 2'd2, 32'h0);
        txn(2'b01, 1'b0, 0, 32'hDEADBEEF);
        set_req(1, 1'b1, 14'h0800, 2'd2, 32'h12345678);
        txn(2'b10, 1'b0, 1, 32'hA5A5A5A5);
        set_req(1, 1'b1, 14'h0006, 2'd2, 32'hCAFEF00D);
        txn(2'b10, 1'b0, 0, 32'h11111111);

        // contention from pointer 0: grants must alternate
        chk("contention_ptr_start", ptr_m, 1'b0);
        set_req(0, 1'b0, 14'h0100, 2'd2, 32'h0);
        set_req(1, 1'b1, 14'h0204, 2'd1, 32'h0BADBEEF);
        for (int i = 0; i < 4; i++) txn(2'b11, 1'b1, i % 2, $urandom);
        req_v_i = 2'b00;

        // backpressure
        set_req(0, 1'b0, 14'h0044, 2'd2, 32'h0);
        txn(2'b01, 1'b0, 5, 32'h5EED5EED);

        // reset during CAPTURE: pointer returns to 0, no response
        set_req(0, 1'b0, 14'h0020, 2'd2, 32'h0);
        set_req(1, 1'b0, 14'h0030, 2'd2, 32'h0);
        txn(2'b01, 1'b0, 0, 32'h22222222);
        chk("pre_reset_ptr", ptr_m, 1'b1);
        apply(); req_v_i = 2'b10;
        tick(); req_v_i = 2'b00; tick();
        reset_i = 1'b1; req_v_i = 2'b11;
        tick();
        chk("midrst_ready", req_ready_o, 2'b00);
        chk("midrst_respv", resp_v_o, 2'b00);
        chk("midrst_en", {write_en_o, read_en_o}, 2'b00);
        reset_i = 1'b0;
        #1;
        chk("midrst_ptr0", req_ready_o, 2'b01);
        req_v_i = 2'b00; ptr_m = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("midrst_quiet", {resp_v_o, write_en_o, read_en_o}, 4'b0000);
        end

        // randomized traffic
        for (int t = 0; t < 24; t++) begin
            for (int n = 0; n < 2; n++) begin
                logic [1:0]  sz;
                logic [13:0] a;
                sz = 2'($urandom_range(0, 2));
                a  = 14'($urandom);
                if ($urandom_range(0, 3) != 0) a = a & ~14'((1 << sz) - 1);
                set_req(n, 1'($urandom), a, sz, $urandom);
            end
            txn(2'($urandom_range(1, 3)), 1'($urandom), int'($urandom_range(0, 3)), $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
